down_counter_timer: RTL and testbench
=====================================

# down_counter_timer

Programmable down-counting timer: loads a start value, decrements by one on each prescaled tick while running, and flags terminal count. Supports one-shot and auto-reload (periodic) operation, plus stop/resume. It complements the free-running up counter in the sequential library and serves as the general countdown/interval source for the design's controllers.

## Interface
- `WIDTH`, 8: counter and load-value width.
- `PRESCALE_W`, 4: prescale-select width. A tick occurs every `prescale+1` cycles.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  load request.
- `load_val`  in  WIDTH  value captured on `load`.
- `start`  in  1  start/resume request.
- `stop`  in  1  pause request.
- `reload_en`  in  1  1 = periodic (auto-reload), 0 = one-shot.
- `prescale`  in  PRESCALE_W  tick divider select.
- `q_out`  out  WIDTH  current count.
- `busy`  out  1  high in state RUN.
- `expired`  out  1  high in state EXPIRED.
- `tc`  out  1  one-cycle terminal-count pulse.

## Operation
- States: IDLE, RUN, EXPIRED.
- Internal registers: `reload_reg` (WIDTH) and prescaler count `pc` (PRESCALE_W).
- Reset state: IDLE. `q_out`=0, `reload_reg`=0, `pc`=0, `tc`=0, `busy`=0, `expired`=0.
- Per-cycle priority: `load` > `stop` > `start` > tick.
- `load` (any state):
  - `q_out`←`load_val`, `reload_reg`←`load_val`, `pc`←0, state←IDLE.
  - `load` aborts a run; a `tc` cannot issue in the same cycle.
- `stop`: RUN→IDLE. `q_out` is held and `pc`←0. In IDLE or EXPIRED it has no effect. It wins over a simultaneous `start`.
- `start` in IDLE:
  - If `q_out`≠0: state←RUN, `pc`←0.
  - If `q_out`=0: ignored.
- `start` in EXPIRED:
  - If `reload_reg`≠0: `q_out`←`reload_reg`, `pc`←0, state←RUN.
  - Otherwise: ignored.
- `start` in RUN: no effect, and the prescaler is not restarted.
- Tick: in RUN, `pc` increments each cycle. When `pc`≥`prescale`, a tick occurs and `pc`←0.
  - Using ≥ means lowering `prescale` mid-run ticks on the next cycle rather than wrapping.
- On a tick with `q_out`>1: `q_out`←`q_out`−1.
- On a tick with `q_out`=1 (terminal), `tc`←1 for exactly one cycle, and:
  - `reload_en`=1 (sampled this cycle): `q_out`←`reload_reg` and state stays RUN. If `reload_reg`=0, `q_out`←0 and state←EXPIRED.
  - `reload_en`=0: `q_out`←0, state←EXPIRED.
- The count never goes below 0 and never wraps to all-ones.

## Timing
- All outputs are registered or decoded directly from the state register. There are no combinational input→output paths.
- `start` sampled at edge N (from IDLE): `busy`=1 after N. First decrement at edge N+`prescale`+1. Subsequent decrements every `prescale`+1 cycles.
- Value V loaded, one-shot: `tc` asserts after edge N+V·(`prescale`+1) and `expired` rises on the same edge.
- Periodic: `tc` pulses every V·(`prescale`+1) cycles with no dead cycle. `q_out` goes 1→V directly.
- `tc` deasserts on the next edge unconditionally.
- Reset asserted mid-run clears everything immediately (asynchronously). After deassertion, the first edge behaves as in IDLE.

## Structure
- Shared package/header `down_counter_timer_pkg`: state encodings (`ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_EXPIRED`=2'd2) and the default widths.
- Sub-module `tick_prescaler`:
  - Contents: the `pc` register and ≥ compare.
  - Inputs: `clk`, `reset`, `en`, `clr`, `prescale`. Output: `tick`.
  - `clr` has priority over `en`.
- Top level: FSM, `q_out`, `reload_reg`, `tc`.

## Test plan
- Reset then idle: `reset`=1 mid-run with `q_out`=5 → `q_out`=0, `busy`=0, `tc`=0, `expired`=0 immediately. `start` afterwards is ignored.
- One-shot: `load_val`=3, `prescale`=0, `reload_en`=0, `start` → `q_out` 3,2,1,0 on consecutive edges. `tc` high one cycle as `q_out` hits 0, `expired`=1. A further `start` reloads 3 and runs.
- Periodic with prescale: `load_val`=2, `prescale`=2, `reload_en`=1 → decrement every 3 cycles. `tc` every 6 cycles. Sequence 2,1,2,1…; `expired` never set.
- Stop/resume: `load_val`=10, `prescale`=0, `stop` after 4 decrements → `q_out`=6 held, `busy`=0. `start` → resumes 5,4,…
- Simultaneous events: `start`+`stop` in IDLE → stays IDLE. `load`=1 with `load_val`=7 in the terminal-tick cycle → `q_out`=7, IDLE, no `tc`. `start` with `q_out`=0 in IDLE → ignored.
- Prescale change mid-run: `prescale`=15 with `pc`=9, change to 3 → tick on the next edge, then every 4 cycles.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared state encodings and default widths for the down-counting timer.
// No logic, no latency, no flow control.
package down_counter_timer_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Tick divider: tick every prescale+1 enabled cycles; tick decodes the registered pc.
// No backpressure; clr wins over en and holds pc at zero.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pc;

    // >= rather than == so a lowered prescale ticks next cycle instead of wrapping
    assign tick = en && !clr && (pc >= prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (en) begin
            if (pc >= prescale) begin
                pc <= '0;
            end else begin
                pc <= pc + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with one-shot / auto-reload and stop/resume.
// All outputs registered or state-decoded (1-cycle response); no backpressure.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  reload_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      q_out,
    output logic                  busy,
    output logic                  expired,
    output logic                  tc
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_d;
    logic             tc_d;
    logic             pc_en;
    logic             pc_clr;
    logic             tick;

    // Outside RUN the prescaler is parked at zero, so every accepted start begins a fresh period
    assign pc_en  = (state_q == ST_RUN);
    assign pc_clr = load || stop || (state_q != ST_RUN);

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (pc_en),
        .clr      (pc_clr),
        .prescale (prescale),
        .tick     (tick)
    );

    assign busy    = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);

    always_comb begin
        state_d  = state_q;
        q_d      = q_out;
        reload_d = reload_reg;
        tc_d     = 1'b0;

        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            state_d  = ST_IDLE;
        end else if (stop) begin
            // stop also masks a same-cycle start in IDLE/EXPIRED
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (start && (state_q == ST_IDLE)) begin
            if (q_out != '0) begin
                state_d = ST_RUN;
            end
        end else if (start && (state_q == ST_EXPIRED)) begin
            if (reload_reg != '0) begin
                q_d     = reload_reg;
                state_d = ST_RUN;
            end
        end else if ((state_q == ST_RUN) && tick) begin
            if (q_out > WIDTH'(1)) begin
                q_d = q_out - WIDTH'(1);
            end else if (q_out == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (reload_en && (reload_reg != '0)) begin
                    q_d = reload_reg;
                end else begin
                    q_d     = '0;
                    state_d = ST_EXPIRED;
                end
            end else begin
                state_d = ST_EXPIRED;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            q_out      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_out      <= q_d;
            reload_reg <= reload_d;
            tc         <= tc_d;
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: expected per-edge outputs are queued
// with each driven cycle and compared one step after the clock edge.
module tb_down_counter_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       reload_en;
    logic [3:0] prescale;
    logic [7:0] q_out;
    logic       busy;
    logic       expired;
    logic       tc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] q;
        logic       b;
        logic       e;
        logic       t;
        string      tag;
    } exp_t;

    exp_t sb[$];

    down_counter_timer #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .stop      (stop),
        .reload_en (reload_en),
        .prescale  (prescale),
        .q_out     (q_out),
        .busy      (busy),
        .expired   (expired),
        .tc        (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // queue the expectation for the coming edge, then compare once the DUT has updated
    task automatic step(input logic [7:0] q, input logic b, input logic e, input logic t,
                        input string tag);
        exp_t x;
        exp_t got;
        x.q = q; x.b = b; x.e = e; x.t = t; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({got.tag, ".q"},       {24'd0, q_out}, {24'd0, got.q});
            check({got.tag, ".busy"},    {31'd0, busy},    {31'd0, got.b});
            check({got.tag, ".expired"}, {31'd0, expired}, {31'd0, got.e});
            check({got.tag, ".tc"},      {31'd0, tc},      {31'd0, got.t});
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step(v, 1'b0, 1'b0, 1'b0, "load");
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        load_val  = 8'd0;
        start     = 1'b0;
        stop      = 1'b0;
        reload_en = 1'b0;
        prescale  = 4'd0;
        #3;
        check("rst.q",       {24'd0, q_out},   32'd0);
        check("rst.busy",    {31'd0, busy},    32'd0);
        check("rst.expired", {31'd0, expired}, 32'd0);
        check("rst.tc",      {31'd0, tc},      32'd0);
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // one-shot, prescale 0
        do_load(8'd3);
        start = 1'b1;
        step(8'd3, 1, 0, 0, "os.start");
        step(8'd2, 1, 0, 0, "os.d2");
        step(8'd1, 1, 0, 0, "os.d1");
        step(8'd0, 0, 1, 1, "os.term");
        step(8'd0, 0, 1, 0, "os.tc_drop");
        start = 1'b1;
        step(8'd3, 1, 0, 0, "os.restart");
        step(8'd2, 1, 0, 0, "os.rerun");
        stop = 1'b1;
        step(8'd2, 0, 0, 0, "os.stop");

        // periodic, prescale 2: tc every 6 cycles, 1 -> 2 directly
        reload_en = 1'b1;
        prescale  = 4'd2;
        do_load(8'd2);
        start = 1'b1;
        step(8'd2, 1, 0, 0, "per.start");
        for (int k = 0; k < 12; k++) begin
            int p;
            p = (k % 6) + 1;
            if (p < 3)       step(8'd2, 1, 0, 0, "per.hi");
            else if (p < 6)  step(8'd1, 1, 0, 0, "per.lo");
            else             step(8'd2, 1, 0, 1, "per.wrap");
        end
        stop = 1'b1;
        step(8'd2, 0, 0, 0, "per.stop");

        // stop / resume
        reload_en = 1'b0;
        prescale  = 4'd0;
        do_load(8'd10);
        start = 1'b1;
        step(8'd10, 1, 0, 0, "sr.start");
        for (int k = 0; k < 4; k++) step(8'(9 - k), 1, 0, 0, "sr.dec");
        stop = 1'b1;
        step(8'd6, 0, 0, 0, "sr.stop");
        step(8'd6, 0, 0, 0, "sr.hold");
        start = 1'b1;
        step(8'd6, 1, 0, 0, "sr.resume");
        step(8'd5, 1, 0, 0, "sr.d5");
        step(8'd4, 1, 0, 0, "sr.d4");
        stop = 1'b1;
        step(8'd4, 0, 0, 0, "sr.stop2");

        // simultaneous events
        start = 1'b1;
        stop  = 1'b1;
        step(8'd4, 0, 0, 0, "sim.start_stop_idle");
        do_load(8'd2);
        start = 1'b1;
        step(8'd2, 1, 0, 0, "sim.start");
        step(8'd1, 1, 0, 0, "sim.d1");
        load     = 1'b1;
        load_val = 8'd7;
        step(8'd7, 0, 0, 0, "sim.load_at_term");
        step(8'd7, 0, 0, 0, "sim.no_tc_after");
        do_load(8'd0);
        start = 1'b1;
        step(8'd0, 0, 0, 0, "sim.start_zero");

        // prescale lowered mid-run: 15 -> 3 with pc at 9
        prescale = 4'd15;
        do_load(8'd20);
        start = 1'b1;
        step(8'd20, 1, 0, 0, "ps.start");
        for (int k = 0; k < 9; k++) step(8'd20, 1, 0, 0, "ps.wait");
        prescale = 4'd3;
        step(8'd19, 1, 0, 0, "ps.fast_tick");
        for (int k = 0; k < 3; k++) step(8'd19, 1, 0, 0, "ps.hold19");
        step(8'd18, 1, 0, 0, "ps.d18");
        for (int k = 0; k < 3; k++) step(8'd18, 1, 0, 0, "ps.hold18");
        step(8'd17, 1, 0, 0, "ps.d17");

        // asynchronous reset mid-run with q_out = 5
        prescale = 4'd0;
        do_load(8'd6);
        start = 1'b1;
        step(8'd6, 1, 0, 0, "ar.start");
        step(8'd5, 1, 0, 0, "ar.d5");
        reset = 1'b1;
        #2;
        check("ar.q",       {24'd0, q_out},   32'd0);
        check("ar.busy",    {31'd0, busy},    32'd0);
        check("ar.expired", {31'd0, expired}, 32'd0);
        check("ar.tc",      {31'd0, tc},      32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        step(8'd0, 0, 0, 0, "ar.start_ignored");

        check("sb.drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
